norm_round_div_sqrt_tp: RTL and testbench

// Post-processing stage directly downstream of the nrbd_nrsc_tp iteration core. It captures the
// pre-normalised mantissa, exponent and round bits on the core's Done pulse, then normalises
// (including denormal right-shift) and rounds per IEEE-754. It packs the result with exception

---
 rtl/norm_round_div_sqrt_tp.sv | 185 ++++++++++++++++++
 tb/tb_norm_round_div_sqrt_tp.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/norm_round_div_sqrt_tp.sv
// Normalise / round / pack stage behind the divide-sqrt iteration core.
// Captures on Done_SI, normalises in NORM, rounds in ROUND, presents the result in HOLD.
module norm_round_div_sqrt_tp #(
  parameter int C_MANT = 23,
  parameter int C_EXP  = 7
) (
  input  logic                     Clk_CI,
  input  logic                     Rst_RBI,
  input  logic                     Done_SI,
  input  logic                     Kill_SI,
  input  logic [C_MANT:0]          Mant_z_DI,
  input  logic [C_EXP+1:0]         Exp_z_DI,
  input  logic [3:0]               Round_bit_DI,
  input  logic                     Sign_DI,
  input  logic [2:0]               RM_DI,
  input  logic                     Nan_SI,
  input  logic                     Inf_SI,
  input  logic                     Zero_SI,
  input  logic                     Nv_SI,
  input  logic                     Dz_SI,
  output logic                     Ready_SO,
  output logic                     Valid_SO,
  input  logic                     Ready_SI,
  output logic [C_MANT+C_EXP+1:0]  Result_DO,
  output logic [4:0]               Fflags_DO,
  output logic                     Overrun_SO
);

  localparam int W_EXT = 2*C_MANT + 4;
  localparam logic signed [C_EXP+2:0] E_ONE  = (C_EXP+3)'(1);
  localparam logic signed [C_EXP+2:0] SH_MAX = (C_EXP+3)'(C_MANT+2);
  localparam logic [C_EXP+2:0] EXP_MAX = {2'b00, {(C_EXP+1){1'b1}}};
  localparam logic [2:0] RM_RNE = 3'b000, RM_RTZ = 3'b001, RM_RDN = 3'b010,
                         RM_RUP = 3'b011, RM_RMM = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_HOLD} state_t;
  state_t r_state, w_state_next;

  logic [C_MANT:0]  r_mant;
  logic [C_EXP+1:0] r_exp;
  logic [3:0]       r_rb;
  logic [2:0]       r_rm;
  logic r_sign, r_nan, r_inf, r_zero, r_nv, r_dz, r_overrun;

  logic [C_MANT:0]  r_nm;
  logic [C_EXP+1:0] r_ne;
  logic r_g, r_s, r_tiny;

  logic [C_MANT+C_EXP+1:0] r_res;
  logic [4:0]              r_flags;

  logic w_capture;
  assign w_capture = Done_SI & Ready_SO & ~Kill_SI;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (Done_SI) w_state_next = S_NORM;
      S_NORM:  w_state_next = S_ROUND;
      S_ROUND: w_state_next = S_HOLD;
      S_HOLD:  if (Ready_SI) w_state_next = Done_SI ? S_NORM : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (Kill_SI) w_state_next = S_IDLE;
  end

  always_comb begin
    Ready_SO = (r_state == S_IDLE) | ((r_state == S_HOLD) & Ready_SI);
    Valid_SO = (r_state == S_HOLD);
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_mant <= '0; r_exp <= '0; r_rb <= '0; r_rm <= '0;
      r_sign <= 1'b0; r_nan <= 1'b0; r_inf <= 1'b0; r_zero <= 1'b0;
      r_nv <= 1'b0; r_dz <= 1'b0; r_overrun <= 1'b0;
    end else begin
      if (w_capture) begin
        r_mant <= Mant_z_DI; r_exp <= Exp_z_DI; r_rb <= Round_bit_DI; r_rm <= RM_DI;
        r_sign <= Sign_DI; r_nan <= Nan_SI; r_inf <= Inf_SI; r_zero <= Zero_SI;
        r_nv <= Nv_SI; r_dz <= Dz_SI;
      end
      if (Done_SI && !Ready_SO) r_overrun <= 1'b1;
    end
  end

  // Normalisation: one-bit left fix-up, then denormal right shift with sticky collection.
  logic signed [C_EXP+2:0] w_e1, w_sh_full, w_sh;
  logic [C_MANT:0] w_m1;
  logic            w_g1, w_s1, w_denorm;
  logic [W_EXT-1:0] w_ext;

  always_comb begin
    if (!r_mant[C_MANT]) begin
      w_m1 = {r_mant[C_MANT-1:0], r_rb[3]};
      w_e1 = $signed({r_exp[C_EXP+1], r_exp}) - E_ONE;
      w_g1 = r_rb[2];
      w_s1 = |r_rb[1:0];
    end else begin
      w_m1 = r_mant;
      w_e1 = $signed({r_exp[C_EXP+1], r_exp});
      w_g1 = r_rb[3];
      w_s1 = |r_rb[2:0];
    end
    w_denorm  = w_e1[C_EXP+2] | (w_e1 == '0);
    w_sh_full = E_ONE - w_e1;
    w_sh      = (w_sh_full > SH_MAX) ? SH_MAX : w_sh_full;
    w_ext     = {w_m1, w_g1, {(C_MANT+2){1'b0}}} >> w_sh;
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_nm <= '0; r_ne <= '0; r_g <= 1'b0; r_s <= 1'b0; r_tiny <= 1'b0;
    end else if (r_state == S_NORM) begin
      if (w_denorm) begin
        r_nm   <= w_ext[W_EXT-1 -: C_MANT+1];
        r_ne   <= '0;
        r_g    <= w_ext[C_MANT+2];
        r_s    <= w_s1 | (|w_ext[C_MANT+1:0]);
        r_tiny <= 1'b1;
      end else begin
        r_nm   <= w_m1;
        r_ne   <= w_e1[C_EXP+1:0];
        r_g    <= w_g1;
        r_s    <= w_s1;
        r_tiny <= 1'b0;
      end
    end
  end

  logic w_inc, w_carry, w_of, w_nx, w_of_inf;
  logic [C_MANT+1:0] w_sum;
  logic [C_EXP+2:0]  w_exp_r;
  logic [C_MANT-1:0] w_frac;
  logic [C_MANT+C_EXP+1:0] w_res;
  logic [4:0] w_flags;

  always_comb begin
    unique case (r_rm)
      RM_RTZ:  begin w_inc = 1'b0;                    w_of_inf = 1'b0;    end
      RM_RDN:  begin w_inc = (r_g | r_s) & r_sign;    w_of_inf = r_sign;  end
      RM_RUP:  begin w_inc = (r_g | r_s) & ~r_sign;   w_of_inf = ~r_sign; end
      RM_RMM:  begin w_inc = r_g;                     w_of_inf = 1'b1;    end
      default: begin w_inc = r_g & (r_s | r_nm[0]);   w_of_inf = 1'b1;    end
    endcase
    w_sum   = {1'b0, r_nm} + {{(C_MANT+1){1'b0}}, w_inc};
    w_carry = w_sum[C_MANT+1];
    w_exp_r = {1'b0, r_ne} + {{(C_EXP+2){1'b0}}, w_carry};
    // A denormal that rounds into the hidden-bit position becomes the smallest normal.
    if (r_ne == '0 && w_sum[C_MANT]) w_exp_r = {{(C_EXP+2){1'b0}}, 1'b1};
    w_frac = w_carry ? '0 : w_sum[C_MANT-1:0];
    w_of   = (w_exp_r >= EXP_MAX);
    w_nx   = r_g | r_s | w_of;
    w_res   = {r_sign, w_exp_r[C_EXP:0], w_frac};
    w_flags = {r_nv, r_dz, w_of, r_tiny & w_nx, w_nx};
    if (w_of) begin
      if (w_of_inf) w_res = {r_sign, {(C_EXP+1){1'b1}}, {C_MANT{1'b0}}};
      else          w_res = {r_sign, {C_EXP{1'b1}}, 1'b0, {C_MANT{1'b1}}};
    end
    if (r_nan || r_inf || r_zero) begin
      w_flags = {r_nv, r_dz, 3'b000};
      if (r_nan)      w_res = {1'b0, {(C_EXP+1){1'b1}}, 1'b1, {(C_MANT-1){1'b0}}};
      else if (r_inf) w_res = {r_sign, {(C_EXP+1){1'b1}}, {C_MANT{1'b0}}};
      else            w_res = {r_sign, {(C_MANT+C_EXP+1){1'b0}}};
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_res <= '0; r_flags <= '0;
    end else if (r_state == S_ROUND) begin
      r_res <= w_res; r_flags <= w_flags;
    end
  end

  assign Result_DO  = r_res;
  assign Fflags_DO  = r_flags;
  assign Overrun_SO = r_overrun;

endmodule

// File: tb/tb_norm_round_div_sqrt_tp.sv
// Directed bench for norm_round_div_sqrt_tp: vector table plus handshake/kill/reset sequences.
module tb_norm_round_div_sqrt_tp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done = 1'b0, kill = 1'b0, ready_in = 1'b0;
  logic [23:0] mant = '0;
  logic [8:0]  expz = '0;
  logic [3:0]  rb = '0;
  logic [2:0]  rm = '0;
  logic sign = 1'b0, nan = 1'b0, inf = 1'b0, zero = 1'b0, nv = 1'b0, dz = 1'b0;
  logic ready_out, valid;
  logic [31:0] result;
  logic [4:0]  fflags;
  logic overrun;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  norm_round_div_sqrt_tp #(.C_MANT(23), .C_EXP(7)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Done_SI(done), .Kill_SI(kill),
    .Mant_z_DI(mant), .Exp_z_DI(expz), .Round_bit_DI(rb), .Sign_DI(sign), .RM_DI(rm),
    .Nan_SI(nan), .Inf_SI(inf), .Zero_SI(zero), .Nv_SI(nv), .Dz_SI(dz),
    .Ready_SO(ready_out), .Valid_SO(valid), .Ready_SI(ready_in),
    .Result_DO(result), .Fflags_DO(fflags), .Overrun_SO(overrun)
  );

  typedef struct {
    logic [23:0] mant; logic [8:0] expz; logic [3:0] rb; logic sign; logic [2:0] rm;
    logic nan; logic inf; logic zero; logic nv; logic dz;
    logic [31:0] res; logic [4:0] flags;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [23:0] m, logic [8:0] e, logic [3:0] r, logic s,
                              logic [2:0] mode, logic [4:0] spec, logic [31:0] res,
                              logic [4:0] fl);
    vec_t v;
    v.mant = m; v.expz = e; v.rb = r; v.sign = s; v.rm = mode;
    {v.nan, v.inf, v.zero, v.nv, v.dz} = spec;
    v.res = res; v.flags = fl;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic drive(vec_t v);
    mant = v.mant; expz = v.expz; rb = v.rb; sign = v.sign; rm = v.rm;
    nan = v.nan; inf = v.inf; zero = v.zero; nv = v.nv; dz = v.dz;
  endtask

  task automatic issue(vec_t v);
    @(negedge clk);
    drive(v);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  // Counts capture edge as 1; returns once Valid_SO is seen or the budget expires.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    // RM: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; spec field = {nan,inf,zero,nv,dz}
    vecs.push_back(mk(24'h800000, 9'd127, 4'h0, 0, 3'd0, 5'b0, 32'h3F800000, 5'h00));
    vecs.push_back(mk(24'h7FFFFF, 9'd127, 4'h8, 0, 3'd0, 5'b0, 32'h3F7FFFFF, 5'h00));
    vecs.push_back(mk(24'h800001, 9'd127, 4'h8, 0, 3'd0, 5'b0, 32'h3F800002, 5'h01));
    vecs.push_back(mk(24'h800001, 9'd127, 4'h8, 0, 3'd1, 5'b0, 32'h3F800001, 5'h01));
    vecs.push_back(mk(24'h800000, 9'd255, 4'h0, 0, 3'd0, 5'b0, 32'h7F800000, 5'h05));
    vecs.push_back(mk(24'h800000, 9'd255, 4'h0, 0, 3'd1, 5'b0, 32'h7F7FFFFF, 5'h05));
    vecs.push_back(mk(24'h800000, 9'd0,   4'h0, 0, 3'd0, 5'b0, 32'h00400000, 5'h00));
    vecs.push_back(mk(24'h800000, 9'd0,   4'h1, 0, 3'd0, 5'b0, 32'h00400000, 5'h03));
    vecs.push_back(mk(24'h800000, 9'd127, 4'h1, 0, 3'd3, 5'b0, 32'h3F800001, 5'h01));
    vecs.push_back(mk(24'h800000, 9'd127, 4'h1, 1, 3'd2, 5'b0, 32'hBF800001, 5'h01));
    vecs.push_back(mk(24'h800000, 9'd127, 4'h1, 0, 3'd2, 5'b0, 32'h3F800000, 5'h01));
    vecs.push_back(mk(24'h800000, 9'd127, 4'h8, 0, 3'd4, 5'b0, 32'h3F800001, 5'h01));
    vecs.push_back(mk(24'h800000, 9'd127, 4'h8, 0, 3'd0, 5'b0, 32'h3F800000, 5'h01));
    vecs.push_back(mk(24'hFFFFFF, 9'd127, 4'h8, 0, 3'd0, 5'b0, 32'h40000000, 5'h01));
    vecs.push_back(mk(24'hFFFFFF, 9'd0,   4'h0, 0, 3'd0, 5'b0, 32'h00800000, 5'h03));
    vecs.push_back(mk(24'hFFFFFF, 9'd254, 4'h8, 0, 3'd0, 5'b0, 32'h7F800000, 5'h05));
    vecs.push_back(mk(24'h800000, 9'd255, 4'h0, 1, 3'd3, 5'b0, 32'hFF7FFFFF, 5'h05));
    vecs.push_back(mk(24'h800000, 9'h1E2, 4'h0, 0, 3'd0, 5'b0, 32'h00000000, 5'h03));
    vecs.push_back(mk(24'h800000, 9'h1E2, 4'h0, 0, 3'd3, 5'b0, 32'h00000001, 5'h03));
    vecs.push_back(mk(24'h400000, 9'd1,   4'h0, 0, 3'd0, 5'b0, 32'h00400000, 5'h00));
    vecs.push_back(mk(24'h800000, 9'd127, 4'h8, 1, 3'd0, 5'b11010, 32'h7FC00000, 5'h10));
    vecs.push_back(mk(24'h800000, 9'd255, 4'h8, 1, 3'd0, 5'b01001, 32'hFF800000, 5'h08));
    vecs.push_back(mk(24'h800000, 9'd127, 4'h8, 1, 3'd0, 5'b00100, 32'h80000000, 5'h00));

    repeat (3) @(negedge clk);
    check("reset_valid",   {31'b0, valid},     32'd0);
    check("reset_result",  result,             32'd0);
    check("reset_flags",   {27'b0, fflags},    32'd0);
    check("reset_overrun", {31'b0, overrun},   32'd0);
    check("reset_ready",   {31'b0, ready_out}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i]);
      wait_valid(lat);
      $display("vec %0d: result=0x%08h flags=%05b latency=%0d", i, result, fflags, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd3);
      check($sformatf("vec%0d_result", i), result, vecs[i].res);
      check($sformatf("vec%0d_flags", i), {27'b0, fflags}, {27'b0, vecs[i].flags});
      handshake();
      check($sformatf("vec%0d_valid_drop", i), {31'b0, valid}, 32'd0);
    end

    // Stall with Ready_SI low, then an overrunning Done, then Kill.
    issue(vecs[0]);
    wait_valid(lat);
    check("stall_latency", lat, 32'd3);
    check("stall_overrun_pre", {31'b0, overrun}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_result", k), result, 32'h3F800000);
      check($sformatf("stall%0d_ready", k), {31'b0, ready_out}, 32'd0);
      check($sformatf("stall%0d_valid", k), {31'b0, valid}, 32'd1);
    end
    drive(vecs[13]);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    $display("stall: overrun=%0b result=0x%08h", overrun, result);
    check("overrun_set", {31'b0, overrun}, 32'd1);
    check("overrun_result_held", result, 32'h3F800000);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    $display("kill in hold: valid=%0b ready=%0b", valid, ready_out);
    check("kill_hold_valid", {31'b0, valid}, 32'd0);
    check("kill_hold_ready", {31'b0, ready_out}, 32'd1);

    // Back-to-back: new Done accepted in the handshake cycle.
    issue(vecs[2]);
    wait_valid(lat);
    check("b2b_first_result", result, 32'h3F800002);
    drive(vecs[13]);
    done = 1'b1;
    ready_in = 1'b1;
    @(negedge clk);
    done = 1'b0;
    ready_in = 1'b0;
    check("b2b_gap_valid", {31'b0, valid}, 32'd0);
    wait_valid(lat);
    $display("b2b: result=0x%08h latency=%0d", result, lat);
    check("b2b_latency", lat, 32'd3);
    check("b2b_result", result, 32'h40000000);
    handshake();

    // Kill while the op is in NORM.
    issue(vecs[0]);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (valid) seen++;
      @(negedge clk);
    end
    $display("kill in norm: valid_cycles=%0d", seen);
    check("kill_norm_no_valid", seen, 32'd0);
    check("kill_norm_ready", {31'b0, ready_out}, 32'd1);

    // Kill and Done in the same IDLE cycle: Kill wins.
    @(negedge clk);
    drive(vecs[0]);
    done = 1'b1;
    kill = 1'b1;
    @(negedge clk);
    done = 1'b0;
    kill = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (valid) seen++;
      @(negedge clk);
    end
    $display("kill+done: valid_cycles=%0d", seen);
    check("kill_beats_done", seen, 32'd0);

    // Asynchronous reset in the middle of an operation.
    issue(vecs[4]);
    #2 rst_n = 1'b0;
    #1;
    $display("reset mid-op: valid=%0b result=0x%08h overrun=%0b", valid, result, overrun);
    check("midrst_valid", {31'b0, valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_overrun", {31'b0, overrun}, 32'd0);
    check("midrst_ready", {31'b0, ready_out}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (valid) seen++;
      @(negedge clk);
    end
    check("midrst_no_pulse", seen, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
